// File: rtl/mastermind_pkg.sv
// Shared constants, state encoding and history entry layout for the Mastermind scorer.
package mastermind_pkg;
  localparam int COLOR_W     = 3;
  localparam int NUM_SLOTS   = 4;
  localparam int MAX_GUESSES = 6;
  localparam int GUESS_W     = COLOR_W * NUM_SLOTS;
  localparam int CNT_W       = 3;
  localparam int IDX_W       = 3;
  localparam int ENTRY_W     = GUESS_W + 2 * CNT_W;
  localparam logic [COLOR_W-1:0] EMPTY_COLOR = '0;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_EXACT  = 5'b00010,
    S_MATCH  = 5'b00100,
    S_COMMIT = 5'b01000,
    S_DONE   = 5'b10000
  } state_e;

  typedef struct packed {
    logic [GUESS_W-1:0] guess;
    logic [CNT_W-1:0]   exact;
    logic [CNT_W-1:0]   color;
  } entry_t;

  function automatic logic [COLOR_W-1:0] slot_of(input logic [GUESS_W-1:0] v, input logic [1:0] k);
    return v[int'(k)*COLOR_W +: COLOR_W];
  endfunction
endpackage

// File: rtl/mastermind_history_buf.sv
// Fixed-depth log of scored guesses; entries at or beyond the valid count read as zero.
module mastermind_history_buf
  import mastermind_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               we_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [IDX_W-1:0]   count_o,
  output logic               full_o,
  output logic [ENTRY_W-1:0] rd_data_o
);
  localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(MAX_GUESSES);

  logic [ENTRY_W-1:0] mem_q [MAX_GUESSES];
  logic [IDX_W-1:0]   count_q;
  logic [IDX_W-1:0]   count_d;
  logic               wr_en;

  assign full_o  = (count_q == MAX_CNT);
  // A clear in the same cycle as a write wins: nothing is stored.
  assign wr_en   = we_i && !clear_i && !full_o;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i)    count_d = '0;
    else if (wr_en) count_d = count_q + 3'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[count_q] <= wdata_i;
  end

  assign rd_data_o = (rd_idx_i < count_q) ? mem_q[rd_idx_i] : '0;
endmodule

// File: rtl/mastermind_scorer.sv
// Multi-cycle Mastermind feedback scorer: exact pass over 4 slots, then a 16-pair colour pass.
module mastermind_scorer
  import mastermind_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [GUESS_W-1:0] guess_i,
  input  logic [GUESS_W-1:0] target_i,
  input  logic               clear_history_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   exact_cnt_o,
  output logic [CNT_W-1:0]   color_cnt_o,
  output logic               win_o,
  output logic [IDX_W-1:0]   hist_count_o,
  output logic               hist_full_o,
  output logic [GUESS_W-1:0] rd_guess_o,
  output logic [CNT_W-1:0]   rd_exact_o,
  output logic [CNT_W-1:0]   rd_color_o,
  output logic [4:0]         dbg_state_o
);
  // Handshake: start_i is taken only in IDLE; busy_o covers every cycle after acceptance
  // through the single done_o cycle, and results stay stable until the next commit.
  state_e state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [GUESS_W-1:0] g_q, g_d, t_q, t_d;
  logic [3:0]         gused_q, gused_d, tused_q, tused_d;
  logic [CNT_W-1:0]   exact_q, exact_d, color_q, color_d;
  logic [CNT_W-1:0]   exact_cnt_q, exact_cnt_d, color_cnt_q, color_cnt_d;
  logic               win_q, win_d;
  logic [1:0]         idx_i, idx_j;
  logic [COLOR_W-1:0] g_sel, t_sel;
  logic               same_color, hist_we;
  entry_t             wr_entry, rd_entry;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_EXACT;
      S_EXACT:  if (cnt_q[1:0] == 2'd3) state_d = S_MATCH;
      S_MATCH:  if (cnt_q == 4'hF) state_d = S_COMMIT;
      S_COMMIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != S_IDLE);
    done_o  = (state_q == S_DONE);
    hist_we = (state_q == S_COMMIT);
  end

  // In EXACT both indices follow the slot counter; in MATCH the counter is {i, j}.
  assign idx_i      = (state_q == S_EXACT) ? cnt_q[1:0] : cnt_q[3:2];
  assign idx_j      = cnt_q[1:0];
  assign g_sel      = slot_of(g_q, idx_i);
  assign t_sel      = slot_of(t_q, idx_j);
  assign same_color = (g_sel != EMPTY_COLOR) && (g_sel == t_sel);

  always_comb begin
    cnt_d       = cnt_q;
    g_d         = g_q;
    t_d         = t_q;
    gused_d     = gused_q;
    tused_d     = tused_q;
    exact_d     = exact_q;
    color_d     = color_q;
    exact_cnt_d = exact_cnt_q;
    color_cnt_d = color_cnt_q;
    win_d       = win_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          g_d     = guess_i;
          t_d     = target_i;
          gused_d = '0;
          tused_d = '0;
          exact_d = '0;
          color_d = '0;
          cnt_d   = '0;
        end
      end
      S_EXACT: begin
        if (same_color) begin
          exact_d        = exact_q + 3'd1;
          gused_d[idx_i] = 1'b1;
          tused_d[idx_j] = 1'b1;
        end
        cnt_d = (cnt_q[1:0] == 2'd3) ? 4'd0 : cnt_q + 4'd1;
      end
      S_MATCH: begin
        if (same_color && !gused_q[idx_i] && !tused_q[idx_j]) begin
          color_d        = color_q + 3'd1;
          gused_d[idx_i] = 1'b1;
          tused_d[idx_j] = 1'b1;
        end
        cnt_d = cnt_q + 4'd1;
      end
      S_COMMIT: begin
        exact_cnt_d = exact_q;
        color_cnt_d = color_q;
        win_d       = (exact_q == 3'd4);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      g_q         <= '0;
      t_q         <= '0;
      gused_q     <= '0;
      tused_q     <= '0;
      exact_q     <= '0;
      color_q     <= '0;
      exact_cnt_q <= '0;
      color_cnt_q <= '0;
      win_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      g_q         <= g_d;
      t_q         <= t_d;
      gused_q     <= gused_d;
      tused_q     <= tused_d;
      exact_q     <= exact_d;
      color_q     <= color_d;
      exact_cnt_q <= exact_cnt_d;
      color_cnt_q <= color_cnt_d;
      win_q       <= win_d;
    end
  end

  assign wr_entry = '{guess: g_q, exact: exact_q, color: color_q};

  mastermind_history_buf u_hist (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_history_i),
    .we_i      (hist_we),
    .wdata_i   (wr_entry),
    .rd_idx_i  (rd_idx_i),
    .count_o   (hist_count_o),
    .full_o    (hist_full_o),
    .rd_data_o (rd_entry)
  );

  assign exact_cnt_o = exact_cnt_q;
  assign color_cnt_o = color_cnt_q;
  assign win_o       = win_q;
  assign rd_guess_o  = rd_entry.guess;
  assign rd_exact_o  = rd_entry.exact;
  assign rd_color_o  = rd_entry.color;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mastermind_scorer.sv
// Bench for mastermind_scorer: colour-histogram reference model checked every cycle plus directed cases.
module tb_mastermind_scorer;
  import mastermind_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] guess;
  logic [11:0] target;
  logic        clear_history;
  logic [2:0]  rd_idx;
  logic        busy, done, win, hist_full;
  logic [2:0]  exact_cnt, color_cnt, hist_count, rd_exact, rd_color;
  logic [11:0] rd_guess;
  logic [4:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  int          m_phase;
  logic [11:0] m_g, m_t;
  int          m_exact, m_color, m_e, m_c;
  logic        m_win;
  logic [17:0] exp_q[$];

  mastermind_scorer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .guess_i         (guess),
    .target_i        (target),
    .clear_history_i (clear_history),
    .rd_idx_i        (rd_idx),
    .busy_o          (busy),
    .done_o          (done),
    .exact_cnt_o     (exact_cnt),
    .color_cnt_o     (color_cnt),
    .win_o           (win),
    .hist_count_o    (hist_count),
    .hist_full_o     (hist_full),
    .rd_guess_o      (rd_guess),
    .rd_exact_o      (rd_exact),
    .rd_color_o      (rd_color),
    .dbg_state_o     (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pk(input int s0, input int s1, input int s2, input int s3);
    return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  // Classic scoring: exact matches, then per-colour minimum of leftover occurrences.
  task automatic score_ref(input logic [11:0] g, input logic [11:0] t, output int e, output int c);
    int gc[8];
    int tc[8];
    logic [2:0] gk, tk;
    for (int k = 0; k < 8; k++) begin
      gc[k] = 0;
      tc[k] = 0;
    end
    e = 0;
    c = 0;
    for (int k = 0; k < 4; k++) begin
      gk = g[3*k +: 3];
      tk = t[3*k +: 3];
      if (gk != 0 && gk == tk) e++;
      else begin
        if (gk != 0) gc[gk]++;
        if (tk != 0) tc[tk]++;
      end
    end
    for (int k = 1; k < 8; k++) c += (gc[k] < tc[k]) ? gc[k] : tc[k];
  endtask

  initial begin
    m_phase = 0; m_exact = 0; m_color = 0; m_win = 1'b0; m_g = '0; m_t = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase = 0; m_exact = 0; m_color = 0; m_win = 1'b0;
        exp_q.delete();
      end else begin
        if (m_phase == 0) begin
          if (start) begin
            m_phase = 1; m_g = guess; m_t = target;
          end
        end else if (m_phase == 21) begin
          score_ref(m_g, m_t, m_e, m_c);
          m_exact = m_e; m_color = m_c; m_win = (m_e == 4);
          if (!clear_history && exp_q.size() < MAX_GUESSES) exp_q.push_back({m_g, 3'(m_e), 3'(m_c)});
          m_phase = 22;
        end else if (m_phase == 22) m_phase = 0;
        else m_phase++;
        if (clear_history) exp_q.delete();
      end
    end
  end

  initial begin
    logic [17:0] ent;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        chk("busy", busy, int'(m_phase != 0));
        chk("done", done, int'(m_phase == 22));
        chk("exact_cnt", exact_cnt, m_exact);
        chk("color_cnt", color_cnt, m_color);
        chk("win", win, m_win);
        chk("hist_count", hist_count, exp_q.size());
        chk("hist_full", hist_full, int'(exp_q.size() == MAX_GUESSES));
        chk("state_onehot", int'($onehot(dbg_state)), 1);
        ent = (int'(rd_idx) < exp_q.size()) ? exp_q[rd_idx] : 18'd0;
        chk("rd_guess", rd_guess, ent[17:6]);
        chk("rd_exact", rd_exact, ent[5:3]);
        chk("rd_color", rd_color, ent[2:0]);
      end
    end
  end

  task automatic score(input logic [11:0] t, input logic [11:0] g, input int exp_e, input int exp_c,
                       input int clr_cyc, input int restart_cyc, input bit clr_with_start);
    int n;
    @(negedge clk);
    start = 1'b1; guess = g; target = t; clear_history = clr_with_start;
    @(negedge clk);
    n = 1;
    forever begin
      clear_history = (n == clr_cyc);
      start         = (n == restart_cyc);
      guess         = 12'($urandom);
      target        = 12'($urandom);
      rd_idx        = 3'($urandom_range(0, 7));
      #1;
      if (done === 1'b1 || n >= 30) break;
      @(negedge clk);
      n++;
    end
    chk("latency", n, 22);
    chk("lit_exact", exact_cnt, exp_e);
    chk("lit_color", color_cnt, exp_c);
    chk("lit_win", win, int'(exp_e == 4));
    @(negedge clk);
    start = 1'b0; clear_history = 1'b0;
  endtask

  task automatic read_entry(input int idx, input logic [11:0] g, input int e, input int c);
    @(negedge clk);
    rd_idx = 3'(idx);
    #1;
    chk("lit_rd_guess", rd_guess, g);
    chk("lit_rd_exact", rd_exact, e);
    chk("lit_rd_color", rd_color, c);
  endtask

  logic [11:0] tv[7];
  logic [11:0] gv[7];
  int          ev[7];
  int          cv[7];

  initial begin
    bit seen;
    tv[0] = pk(1,2,3,4); gv[0] = pk(1,2,3,4); ev[0] = 4; cv[0] = 0;
    tv[1] = pk(1,2,3,4); gv[1] = pk(4,3,2,1); ev[1] = 0; cv[1] = 4;
    tv[2] = pk(0,0,0,0); gv[2] = pk(0,0,0,0); ev[2] = 0; cv[2] = 0;
    tv[3] = pk(1,1,2,2); gv[3] = pk(1,2,1,3); ev[3] = 1; cv[3] = 2;
    tv[4] = pk(1,2,3,4); gv[4] = pk(1,1,1,1); ev[4] = 1; cv[4] = 0;
    tv[5] = pk(1,2,3,4); gv[5] = pk(0,2,3,4); ev[5] = 3; cv[5] = 0;
    tv[6] = pk(5,6,7,7); gv[6] = pk(7,7,5,6); ev[6] = 0; cv[6] = 4;

    rst = 1'b1; start = 1'b0; clear_history = 1'b0; guess = '0; target = '0; rd_idx = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_win", win, 0);
    chk("rst_exact", exact_cnt, 0);
    chk("rst_color", color_cnt, 0);
    chk("rst_hist_count", hist_count, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      score(tv[i], gv[i], ev[i], cv[i], -1, -1, 1'b0);
      if (i == 0) begin
        read_entry(0, pk(1,2,3,4), 4, 0);
        chk("lit_hist_count_1", hist_count, 1);
      end
    end
    #1;
    chk("lit_hist_count_full", hist_count, 6);
    chk("lit_hist_full", hist_full, 1);
    read_entry(5, pk(0,2,3,4), 3, 0);
    read_entry(6, 12'd0, 0, 0);
    read_entry(7, 12'd0, 0, 0);

    @(negedge clk); clear_history = 1'b1;
    @(negedge clk); clear_history = 1'b0;
    #1;
    chk("lit_clear", hist_count, 0);

    score(pk(1,2,3,4), pk(4,3,2,1), 0, 4, -1, -1, 1'b0);
    score(pk(1,2,3,4), pk(1,2,3,4), 4, 0, -1, -1, 1'b1);
    #1;
    chk("lit_clear_start_count", hist_count, 1);
    read_entry(0, pk(1,2,3,4), 4, 0);

    score(pk(1,1,2,2), pk(1,2,1,3), 1, 2, 21, -1, 1'b0);
    #1;
    chk("lit_clear_commit_count", hist_count, 0);

    score(pk(1,2,3,4), pk(0,2,3,4), 3, 0, -1, 5, 1'b0);
    read_entry(0, pk(0,2,3,4), 3, 0);

    @(negedge clk); clear_history = 1'b1;
    @(negedge clk); clear_history = 1'b0;
    start = 1'b1; guess = pk(1,2,3,4); target = pk(1,2,3,4);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("lit_rst_mid_busy", busy, 0);
    chk("lit_rst_mid_hist", hist_count, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("lit_no_done_after_rst", int'(seen), 0);
    chk("lit_hist_after_rst", hist_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
